prng_stream_gen: RTL

- Parametrised Galois-LFSR pseudo-random number generator with a start/stop/burst controller and a valid/ready output handshake.
- Successor to the free-running 8-bit generator: width, taps and seed are now parameters, the seed is runtime-loadable, and all-zero lockup is protected.
- Sits between the random source and downstream consumers (stimulus engines, file dumpers) that may stall.

---
 rtl/prng_stream_gen.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/prng_stream_gen.sv
// prng_stream_gen: parametrised Galois-LFSR random source with a start/stop/burst
// controller and a valid/ready output slot. The LFSR advances only when a sample
// is generated. The seed can be loaded at runtime, and an all-zero state is
// never allowed to persist.
module prng_stream_gen #(
    parameter int                WIDTH = 16,
    parameter int                OUT_W = 8,
    parameter logic [WIDTH-1:0]  POLY  = 16'hB400,
    parameter logic [WIDTH-1:0]  SEED  = 16'hACE1,
    parameter int                CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [WIDTH-1:0]  seed_i,
    input  logic              start,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              stop,
    output logic [OUT_W-1:0]  number_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              lockup_o,
    output logic [CNT_W-1:0]  count_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_t;

    fsm_t              fsm_q;
    logic [WIDTH-1:0]  lfsr_q;
    logic [WIDTH-1:0]  lfsr_next;
    logic [CNT_W-1:0]  remaining_q;
    logic              xfer;
    logic              slot_free;

    // A transfer completes whenever the consumer takes a presented sample.
    assign xfer      = valid_o && ready_i;
    // The output slot can take a new sample when empty or being emptied this edge.
    assign slot_free = !valid_o || ready_i;

    // One Galois step of the LFSR: shift right, fold in the polynomial on a 1 out.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the signal
        // unassigned, which would otherwise infer a latch.
        lfsr_next = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_next = lfsr_next ^ POLY;
        end
    end

    // Controller, LFSR state, output slot and transfer counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q       <= IDLE;
            lfsr_q      <= SEED;
            remaining_q <= '0;
            number_o    <= '0;
            valid_o     <= 1'b0;
            busy_o      <= 1'b0;
            lockup_o    <= 1'b0;
            count_o     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values, independent of statement order.
            lockup_o <= 1'b0;

            // Every completed transfer counts, whatever the controller is doing.
            if (xfer) begin
                count_o <= count_o + CNT_W'(1);
            end

            case (fsm_q)
                IDLE: begin
                    // A seed load wins over start; start is dropped that cycle.
                    if (seed_load) begin
                        if (seed_i == '0) begin
                            lfsr_q   <= SEED;
                            lockup_o <= 1'b1;
                        end else begin
                            lfsr_q <= seed_i;
                        end
                    end else if (start) begin
                        fsm_q       <= RUN;
                        busy_o      <= 1'b1;
                        remaining_q <= burst_len;
                    end
                end

                RUN: begin
                    if (stop) begin
                        // Stop beats generation, even on the last burst slot. A sample
                        // taken on this same edge still leaves the slot.
                        fsm_q <= DRAIN;
                        if (xfer) begin
                            valid_o <= 1'b0;
                        end
                    end else if (slot_free) begin
                        // Generation slot: advance the LFSR and present its low bits.
                        if (lfsr_next == '0) begin
                            lfsr_q   <= SEED;
                            number_o <= SEED[OUT_W-1:0];
                            lockup_o <= 1'b1;
                        end else begin
                            lfsr_q   <= lfsr_next;
                            number_o <= lfsr_next[OUT_W-1:0];
                        end
                        valid_o <= 1'b1;

                        // A zero count means continuous mode, so it never ends a burst.
                        if (remaining_q != '0) begin
                            remaining_q <= remaining_q - CNT_W'(1);
                            if (remaining_q == CNT_W'(1)) begin
                                fsm_q <= DRAIN;
                            end
                        end
                    end
                end

                DRAIN: begin
                    // The slot is cleared on a transfer first. Busy drops one cycle
                    // after valid falls.
                    if (!valid_o) begin
                        fsm_q  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (ready_i) begin
                        valid_o <= 1'b0;
                    end
                end

                default: begin
                    fsm_q  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
